// File: rtl/msdap_pkg.sv
// Shared types and stream geometry for the MSDAP serial receive path.
package msdap_pkg;

  localparam int MSDAP_WORD_W   = 16;
  localparam int MSDAP_NUM_RJ   = 16;
  localparam int MSDAP_NUM_COEF = 512;

  typedef enum logic [1:0] {
    RJ   = 2'd0,
    COEF = 2'd1,
    DATA = 2'd2
  } word_kind_e;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/msdap_frame_rx_if.sv
// Word bus from the serial framer to the Rj/coefficient memories and data buffer.
interface msdap_frame_rx_if
  import msdap_pkg::*;
  #(parameter int WORD_W = MSDAP_WORD_W);

  logic [WORD_W-1:0] WordL;
  logic [WORD_W-1:0] WordR;
  logic              WordValid;
  word_kind_e        WordKind;
  logic [9:0]        WordIdx;
  logic              FrameErr;

  modport master (
    output WordL, WordR, WordValid, WordKind, WordIdx, FrameErr
  );

  modport slave (
    input WordL, WordR, WordValid, WordKind, WordIdx, FrameErr
  );

endinterface

// File: rtl/msdap_sync.sv
// Multi-bit flop chain; every bit sees the same delay so related inputs stay aligned.
module msdap_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/msdap_frame_rx.sv
// MSDAP serial front end: oversamples DCLK/Frame/InputL/InputR in the SCLK domain,
// deserializes Frame-delimited 16-bit stereo words and tags them as Rj, coefficient or data.
module msdap_frame_rx
  import msdap_pkg::*;
#(
  parameter int WORD_W      = MSDAP_WORD_W,
  parameter int NUM_RJ      = MSDAP_NUM_RJ,
  parameter int NUM_COEF    = MSDAP_NUM_COEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic SCLK,
  input  logic Reset,
  input  logic Restart,
  input  logic En,
  input  logic DCLK,
  input  logic Frame,
  input  logic InputL,
  input  logic InputR,
  msdap_frame_rx_if.master wordBus
);

  localparam int CNT_W     = $clog2(WORD_W);
  localparam int TOTAL_MAX = NUM_RJ + NUM_COEF;
  localparam int TOTAL_W   = $clog2(TOTAL_MAX) + 1;

  logic [3:0] syncQ;
  logic       dclkS, frameS, inLS, inRS;
  logic       dclkD, fall;

  msdap_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync (
    .clk (SCLK),
    .rst (Reset),
    .d   ({DCLK, Frame, InputL, InputR}),
    .q   (syncQ)
  );

  assign {dclkS, frameS, inLS, inRS} = syncQ;

  always_ff @(posedge SCLK) begin
    if (Reset) dclkD <= 1'b0;
    else       dclkD <= dclkS;
  end

  assign fall = dclkD & ~dclkS;

  rx_state_e          state, stateNext;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  shL, shR;
  logic [TOTAL_W-1:0] total;
  logic               startBit, shiftBit, abortWord, wordDone;
  word_kind_e         kindNow;
  logic [9:0]         idxNow;

  always_ff @(posedge SCLK) begin
    if (Reset || Restart) state <= RX_IDLE;
    else                  state <= stateNext;
  end

  // cnt counts modulo WORD_W: in SHIFT, cnt==0 means all WORD_W bits are in.
  always_comb begin
    stateNext = state;
    if (!En) begin
      stateNext = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE:  if (fall && frameS) stateNext = RX_SHIFT;
        RX_SHIFT: if (cnt == '0)      stateNext = RX_IDLE;
        default:  stateNext = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    startBit  = 1'b0;
    shiftBit  = 1'b0;
    abortWord = 1'b0;
    wordDone  = 1'b0;
    if (En) begin
      case (state)
        RX_IDLE: startBit = fall & frameS;
        RX_SHIFT: begin
          if (cnt == '0) begin
            wordDone = 1'b1;
          end else if (fall) begin
            if (frameS) begin
              startBit  = 1'b1;
              abortWord = 1'b1;
            end else begin
              shiftBit = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    kindNow = DATA;
    idxNow  = '0;
    if (total < TOTAL_W'(NUM_RJ)) begin
      kindNow = RJ;
      idxNow  = 10'(total);
    end else if (total < TOTAL_W'(TOTAL_MAX)) begin
      kindNow = COEF;
      idxNow  = 10'(total - TOTAL_W'(NUM_RJ));
    end
  end

  always_ff @(posedge SCLK) begin
    if (Reset) begin
      cnt               <= '0;
      shL               <= '0;
      shR               <= '0;
      total             <= '0;
      wordBus.WordL     <= '0;
      wordBus.WordR     <= '0;
      wordBus.WordValid <= 1'b0;
      wordBus.WordKind  <= RJ;
      wordBus.WordIdx   <= '0;
      wordBus.FrameErr  <= 1'b0;
    end else if (Restart) begin
      cnt               <= '0;
      total             <= '0;
      wordBus.WordValid <= 1'b0;
      wordBus.FrameErr  <= 1'b0;
    end else begin
      wordBus.WordValid <= wordDone;
      wordBus.FrameErr  <= abortWord;
      if (!En) begin
        cnt <= '0;
      end else if (startBit) begin
        shL <= WORD_W'(inLS);
        shR <= WORD_W'(inRS);
        cnt <= CNT_W'(1);
      end else if (shiftBit) begin
        shL <= {shL[WORD_W-2:0], inLS};
        shR <= {shR[WORD_W-2:0], inRS};
        cnt <= cnt + CNT_W'(1);
      end else if (wordDone) begin
        wordBus.WordL    <= shL;
        wordBus.WordR    <= shR;
        wordBus.WordKind <= kindNow;
        wordBus.WordIdx  <= idxNow;
        if (total != TOTAL_W'(TOTAL_MAX)) total <= total + TOTAL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_msdap_frame_rx.sv
// Directed bench for msdap_frame_rx: frame timing, classification boundaries, abort, enable, restart, reset.
`timescale 1ns/100ps
module tb_msdap_frame_rx;
  import msdap_pkg::*;

  logic SCLK = 1'b0;
  logic Reset, Restart, En, DCLK, Frame, InputL, InputR;

  msdap_frame_rx_if bus ();

  msdap_frame_rx dut (
    .SCLK    (SCLK),
    .Reset   (Reset),
    .Restart (Restart),
    .En      (En),
    .DCLK    (DCLK),
    .Frame   (Frame),
    .InputL  (InputL),
    .InputR  (InputR),
    .wordBus (bus)
  );

  always #18.6 SCLK = ~SCLK;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int ecount = 0;
  int b2b    = 0;
  logic prevValid = 1'b0;
  logic [1:0]  logKind [0:1023];
  logic [9:0]  logIdx  [0:1023];
  logic [15:0] logL    [0:1023];

  always @(negedge SCLK) begin
    if (bus.WordValid === 1'b1) begin
      if (vcount < 1024) begin
        logKind[vcount] = bus.WordKind;
        logIdx[vcount]  = bus.WordIdx;
        logL[vcount]    = bus.WordL;
      end
      vcount++;
      if (prevValid) b2b++;
    end
    prevValid = (bus.WordValid === 1'b1);
    if (bus.FrameErr === 1'b1) ecount++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge SCLK);
    #1;
  endtask

  // Sends the first nbits of an MSB-first word; data changes on DCLK rise.
  task automatic sendBits(input logic [15:0] l, input logic [15:0] r, input int nbits,
                          input realtime half, input bit measure, output int lat);
    lat = 0;
    @(posedge SCLK);
    #5;
    for (int i = 0; i < nbits; i++) begin
      DCLK   = 1'b1;
      Frame  = (i == 0);
      InputL = l[15-i];
      InputR = r[15-i];
      #(half);
      DCLK = 1'b0;
      if (measure && i == nbits - 1) begin
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
          @(posedge SCLK);
          #1;
          if (bus.WordValid === 1'b1 && lat < 0) lat = k;
        end
      end
      #(half);
    end
    Frame = 1'b0;
  endtask

  initial begin
    int lat, v0, e0, b0;
    Reset = 1'b1; Restart = 1'b0; En = 1'b1;
    DCLK = 1'b0; Frame = 1'b0; InputL = 1'b0; InputR = 1'b0;
    tick(4);
    chk("rst_WordL", bus.WordL, 0);
    chk("rst_WordR", bus.WordR, 0);
    chk("rst_WordValid", bus.WordValid, 0);
    chk("rst_WordKind", bus.WordKind, RJ);
    chk("rst_WordIdx", bus.WordIdx, 0);
    chk("rst_FrameErr", bus.FrameErr, 0);
    Reset = 1'b0;
    tick(3);

    v0 = vcount;
    sendBits(16'hA5C3, 16'h0001, 16, 651.0, 1'b1, lat);
    tick(4);
    chk("first_latency", lat, 4);
    chk("first_count", vcount - v0, 1);
    chk("first_WordL", bus.WordL, 16'hA5C3);
    chk("first_WordR", bus.WordR, 16'h0001);
    chk("first_kind", bus.WordKind, RJ);
    chk("first_idx", bus.WordIdx, 0);

    v0 = vcount; e0 = ecount;
    sendBits(16'hFFFF, 16'hFFFF, 7, 74.4, 1'b0, lat);
    sendBits(16'h1234, 16'hBEEF, 16, 74.4, 1'b0, lat);
    tick(6);
    chk("abort_ferr", ecount - e0, 1);
    chk("abort_count", vcount - v0, 1);
    chk("abort_WordL", bus.WordL, 16'h1234);
    chk("abort_WordR", bus.WordR, 16'hBEEF);
    chk("abort_idx", bus.WordIdx, 1);

    v0 = vcount; e0 = ecount;
    sendBits(16'hFFFF, 16'h0000, 8, 74.4, 1'b0, lat);
    tick(2);
    En = 1'b0;
    tick(3);
    En = 1'b1;
    tick(2);
    sendBits(16'h8000, 16'h7FFF, 16, 74.4, 1'b0, lat);
    tick(6);
    chk("en_ferr", ecount - e0, 0);
    chk("en_count", vcount - v0, 1);
    chk("en_WordL", bus.WordL, 16'h8000);
    chk("en_WordR", bus.WordR, 16'h7FFF);
    chk("en_idx", bus.WordIdx, 2);

    for (int i = 3; i < 20; i++) sendBits(16'(i), 16'h0, 16, 74.4, 1'b0, lat);
    tick(6);
    chk("w19_kind", bus.WordKind, COEF);
    chk("w19_idx", bus.WordIdx, 3);
    Restart = 1'b1;
    tick(1);
    Restart = 1'b0;
    chk("restart_WordValid", bus.WordValid, 0);
    chk("restart_hold_WordL", bus.WordL, 16'd19);
    tick(2);
    sendBits(16'h0F0F, 16'hF0F0, 16, 74.4, 1'b0, lat);
    tick(6);
    chk("restart_kind", bus.WordKind, RJ);
    chk("restart_idx", bus.WordIdx, 0);
    chk("restart_WordL", bus.WordL, 16'h0F0F);

    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(2);
    v0 = vcount; b0 = b2b;
    for (int i = 0; i < 531; i++) sendBits(16'(i), ~16'(i), 16, 74.4, 1'b0, lat);
    tick(6);
    chk("bulk_count", vcount - v0, 531);
    chk("w15_kind", logKind[v0+15], RJ);
    chk("w15_idx", logIdx[v0+15], 15);
    chk("w16_kind", logKind[v0+16], COEF);
    chk("w16_idx", logIdx[v0+16], 0);
    chk("w527_kind", logKind[v0+527], COEF);
    chk("w527_idx", logIdx[v0+527], 511);
    for (int k = 528; k < 531; k++) begin
      chk("data_kind", logKind[v0+k], DATA);
      chk("data_idx", logIdx[v0+k], 0);
    end
    chk("w530_WordL", logL[v0+530], 16'd530);
    chk("back_to_back", b2b - b0, 0);

    sendBits(16'hFFFF, 16'hFFFF, 8, 74.4, 1'b0, lat);
    chk("pre_reset_kind", bus.WordKind, DATA);
    Reset = 1'b1;
    tick(1);
    chk("midrst_WordL", bus.WordL, 0);
    chk("midrst_WordR", bus.WordR, 0);
    chk("midrst_WordValid", bus.WordValid, 0);
    chk("midrst_kind", bus.WordKind, RJ);
    chk("midrst_idx", bus.WordIdx, 0);
    chk("midrst_FrameErr", bus.FrameErr, 0);
    Reset = 1'b0;
    tick(2);
    sendBits(16'h5A5A, 16'hA5A5, 16, 74.4, 1'b0, lat);
    tick(6);
    chk("postrst_kind", bus.WordKind, RJ);
    chk("postrst_idx", bus.WordIdx, 0);
    chk("postrst_WordL", bus.WordL, 16'h5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
